// File: rtl/simple_pipe_fetch.sv
// rtl/simple_pipe_fetch.sv - in-order instruction fetch with credit-limited queue and redirect flush
// Optional macro SIMPLE_PIPE_FETCH_BYPASS_EN: same-cycle response-to-decode bypass on an empty queue.
module simple_pipe_fetch #(
  parameter int QDEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req_valid,
  input  logic       imem_req_ready,
  output logic [7:0] imem_req_addr,
  input  logic       imem_resp_valid,
  input  logic [7:0] imem_resp_data,
  output logic [7:0] inst,
  output logic       inst_valid,
  input  logic       inst_ready,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] QDEPTH_W = (CW + 1)'(QDEPTH);

  logic [7:0]    pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]    mem_q [QDEPTH];

  logic [CW:0] credit_used;
  logic        req_hs;
  logic        resp_ok;
  logic        discard;
  logic        head_valid;
  logic        bypass_take;
  logic        push;
  logic        pop;

  always_comb begin
    credit_used    = {1'b0, inflight_q} + {1'b0, count_q};
    imem_req_valid = !rst && (credit_used < QDEPTH_W);
    imem_req_addr  = pc_q;
    req_hs         = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol violation and is ignored.
    resp_ok        = imem_resp_valid && (inflight_q != '0);
    discard        = resp_ok && (drop_q != '0);
    head_valid     = !rst && (count_q != '0) && !redirect_valid;
`ifdef SIMPLE_PIPE_FETCH_BYPASS_EN
    if (!rst && resp_ok && (drop_q == '0) && (count_q == '0) && !redirect_valid) begin
      inst        = imem_resp_data;
      inst_valid  = 1'b1;
      bypass_take = inst_ready;
    end else begin
      inst        = mem_q[rd_ptr_q];
      inst_valid  = head_valid;
      bypass_take = 1'b0;
    end
`else
    inst        = mem_q[rd_ptr_q];
    inst_valid  = head_valid;
    bypass_take = 1'b0;
`endif
    push = resp_ok && (drop_q == '0) && !bypass_take && !redirect_valid;
    pop  = head_valid && inst_ready;
  end

  always_comb begin
    pc_d       = req_hs ? pc_q + 8'd1 : pc_q;
    inflight_d = inflight_q + CW'(req_hs) - CW'(resp_ok);
    drop_d     = drop_q - CW'(discard);
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    // Everything still outstanding after this cycle (including a request
    // accepted right now) belongs to the old path and must be discarded.
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      drop_d   = inflight_d;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= 8'h00;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_simple_pipe_fetch.sv
// tb/tb_simple_pipe_fetch.sv - randomized self-checking bench for simple_pipe_fetch
// Reference model: queues of outstanding fetches and expected instructions.
module tb_simple_pipe_fetch;
  localparam int QDEPTH = 4;

  logic       clk;
  logic       rst;
  logic       imem_req_valid;
  logic       imem_req_ready;
  logic [7:0] imem_req_addr;
  logic       imem_resp_valid;
  logic [7:0] imem_resp_data;
  logic [7:0] inst;
  logic       inst_valid;
  logic       inst_ready;
  logic       redirect_valid;
  logic [7:0] redirect_pc;

  simple_pipe_fetch #(.QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         due;
    bit         stale;
  } ent_t;

  ent_t       env_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] hs_log[$];
  logic [7:0] pop_log[$];
  logic [7:0] exp_pc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int k_rr, k_ir, k_redir, k_spur, k_lat_min, k_lat_max;
  bit force_redir;
  logic [7:0] redir_target;
  logic last_iv;

  function automatic logic [7:0] mem_f(input logic [7:0] a);
    logic [7:0] r;
    r = a * 8'd13;
    return r ^ 8'h5A;
  endfunction

  task automatic set_knobs(input int rr, input int ir, input int lmin, input int lmax,
                           input int redir, input int spur);
    k_rr = rr; k_ir = ir; k_lat_min = lmin; k_lat_max = lmax;
    k_redir = redir; k_spur = spur;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 8'h00;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    env_q.delete(); exp_q.delete();
    exp_pc = 8'h00;
    force_redir = 1'b0;
  endtask

  // One clock of environment + reference model; checks every DUT output.
  task automatic drive_cycle();
    ent_t e, n;
    bit resp, spur, redir, exp_rv, exp_iv, hs, pop;
    logic [7:0] rpc;
    @(negedge clk);
    cyc++;
    imem_req_ready = ($urandom_range(99) < k_rr);
    inst_ready     = ($urandom_range(99) < k_ir);
    redir          = force_redir || ($urandom_range(99) < k_redir);
    rpc            = force_redir ? redir_target : 8'($urandom);
    force_redir    = 1'b0;
    redirect_valid = redir;
    redirect_pc    = rpc;
    resp = (env_q.size() != 0) && (env_q[0].due <= cyc);
    spur = (env_q.size() == 0) && ($urandom_range(99) < k_spur);
    imem_resp_valid = resp || spur;
    imem_resp_data  = resp ? env_q[0].data : 8'($urandom);
    #1;
    exp_rv = (env_q.size() + exp_q.size()) < QDEPTH;
    exp_iv = (exp_q.size() != 0) && !redir;
    checks++;
    if (imem_req_valid !== exp_rv) begin
      errors++;
      $display("FAIL req_valid cyc %0d got %b exp %b", cyc, imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      checks++;
      if (imem_req_addr !== exp_pc) begin
        errors++;
        $display("FAIL req_addr cyc %0d got %h exp %h", cyc, imem_req_addr, exp_pc);
      end
    end
    checks++;
    if (inst_valid !== exp_iv) begin
      errors++;
      $display("FAIL inst_valid cyc %0d got %b exp %b", cyc, inst_valid, exp_iv);
    end
    if (exp_iv) begin
      checks++;
      if (inst !== exp_q[0]) begin
        errors++;
        $display("FAIL inst cyc %0d got %h exp %h", cyc, inst, exp_q[0]);
      end
    end
    last_iv = inst_valid;
    hs  = exp_rv && imem_req_ready;
    pop = exp_iv && inst_ready;
    if (hs)  hs_log.push_back(imem_req_addr);
    if (pop) pop_log.push_back(inst);
    if (resp) e = env_q.pop_front();
    if (hs) begin
      n.addr  = exp_pc;
      n.data  = mem_f(exp_pc);
      n.due   = cyc + int'($urandom_range(k_lat_max, k_lat_min));
      n.stale = redir;
    end
    if (redir) begin
      exp_q.delete();
      foreach (env_q[i]) env_q[i].stale = 1'b1;
      exp_pc = rpc;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (resp && !e.stale) exp_q.push_back(e.data);
      if (hs) exp_pc = exp_pc + 8'd1;
    end
    if (hs) env_q.push_back(n);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
    imem_resp_valid = 1'b0; redirect_pc = 8'h00; imem_resp_data = 8'h00;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid);
    end
    do_reset();
    #1;
    checks++;
    if (imem_req_addr !== 8'h00) begin
      errors++; $display("FAIL reset_addr got %h exp 00", imem_req_addr);
    end
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid);
    end
    checks++;
    if (imem_req_valid !== 1'b1) begin
      errors++; $display("FAIL post_reset_req_valid got %b exp 1", imem_req_valid);
    end
  endtask

  task automatic test_streaming();
    int hb, pb;
    do_reset();
    set_knobs(100, 100, 1, 1, 0, 0);
    hb = hs_log.size(); pb = pop_log.size();
    run(20);
    checks++;
    if (pop_log.size() - pb != 18) begin
      errors++; $display("FAIL stream_pops got %0d exp 18", pop_log.size() - pb);
    end
    checks++;
    if (hs_log[hb] !== 8'h00 || hs_log[hb+1] !== 8'h01 || hs_log[hb+2] !== 8'h02) begin
      errors++;
      $display("FAIL stream_addrs got %h %h %h exp 00 01 02", hs_log[hb], hs_log[hb+1], hs_log[hb+2]);
    end
  endtask

  task automatic test_full_stall();
    int hb, pb;
    do_reset();
    set_knobs(100, 0, 1, 1, 0, 0);
    hb = hs_log.size();
    run(10);
    checks++;
    if (hs_log.size() - hb != 4) begin
      errors++; $display("FAIL stall_handshakes got %0d exp 4", hs_log.size() - hb);
    end
    pb = pop_log.size();
    set_knobs(100, 100, 1, 1, 0, 0);
    run(8);
    checks++;
    if (hs_log.size() <= hb + 4 || hs_log[hb+4] !== 8'h04) begin
      errors++; $display("FAIL stall_resume_addr got %h exp 04", hs_log[hb+4]);
    end
    checks++;
    if (pop_log.size() < pb + 4 || pop_log[pb] !== mem_f(8'h00) || pop_log[pb+3] !== mem_f(8'h03)) begin
      errors++; $display("FAIL stall_drain_order got %h exp %h", pop_log[pb], mem_f(8'h00));
    end
  endtask

  task automatic test_redirect();
    int hb, pb;
    do_reset();
    set_knobs(0, 100, 6, 6, 0, 0);
    force_redir = 1'b1; redir_target = 8'h10;
    run(1);
    hb = hs_log.size();
    set_knobs(100, 100, 6, 6, 0, 0);
    run(3);
    set_knobs(0, 100, 1, 1, 0, 0);
    force_redir = 1'b1; redir_target = 8'h40;
    pb = pop_log.size();
    run(1);
    set_knobs(100, 100, 1, 1, 0, 0);
    run(20);
    checks++;
    if (hs_log[hb] !== 8'h10 || hs_log[hb+2] !== 8'h12 || hs_log[hb+3] !== 8'h40) begin
      errors++; $display("FAIL redir_addrs got %h %h %h exp 10 12 40", hs_log[hb], hs_log[hb+2], hs_log[hb+3]);
    end
    checks++;
    if (pop_log.size() <= pb || pop_log[pb] !== mem_f(8'h40)) begin
      errors++; $display("FAIL redir_first_inst got %h exp %h", pop_log[pb], mem_f(8'h40));
    end
  endtask

  task automatic test_wrap();
    int hb;
    do_reset();
    set_knobs(0, 100, 1, 1, 0, 0);
    force_redir = 1'b1; redir_target = 8'hFE;
    run(1);
    hb = hs_log.size();
    set_knobs(100, 100, 1, 1, 0, 0);
    run(3);
    checks++;
    if (hs_log[hb] !== 8'hFE || hs_log[hb+1] !== 8'hFF || hs_log[hb+2] !== 8'h00) begin
      errors++; $display("FAIL wrap_addrs got %h %h %h exp fe ff 00", hs_log[hb], hs_log[hb+1], hs_log[hb+2]);
    end
  endtask

  task automatic test_redirect_same_cycle();
    int hb, pb;
    do_reset();
    set_knobs(100, 0, 2, 2, 0, 0);
    run(3);
    hb = hs_log.size();
    set_knobs(100, 100, 2, 2, 0, 0);
    force_redir = 1'b1; redir_target = 8'h80;
    run(1);
    checks++;
    if (hs_log.size() != hb + 1 || hs_log[hb] !== 8'h03) begin
      errors++; $display("FAIL same_cycle_hs got %0d entries addr %h exp 1 addr 03", hs_log.size() - hb, hs_log[hb]);
    end
    set_knobs(0, 100, 2, 2, 0, 0);
    run(1);
    checks++;
    if (last_iv !== 1'b0) begin
      errors++; $display("FAIL same_cycle_empty got %b exp 0", last_iv);
    end
    pb = pop_log.size();
    set_knobs(100, 100, 1, 1, 0, 0);
    run(20);
    checks++;
    if (pop_log.size() <= pb || pop_log[pb] !== mem_f(8'h80)) begin
      errors++; $display("FAIL same_cycle_first_inst got %h exp %h", pop_log[pb], mem_f(8'h80));
    end
  endtask

  task automatic test_random();
    int pb;
    do_reset();
    pb = pop_log.size();
    set_knobs(70, 60, 1, 4, 3, 5);
    run(3000);
    checks++;
    if (pop_log.size() - pb < 200) begin
      errors++; $display("FAIL random_progress got %0d exp >=200", pop_log.size() - pb);
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 8'h00;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    force_redir = 1'b0; redir_target = 8'h00; exp_pc = 8'h00; last_iv = 1'b0;
    set_knobs(0, 0, 1, 1, 0, 0);
    test_reset();
    test_streaming();
    test_full_stall();
    test_redirect();
    test_wrap();
    test_redirect_same_cycle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
